// File: rtl/pacman_motion.sv
// Pac-Man per-frame motion controller: probes the maze wall lookup at the
// leading edge of the candidate sprite position, then moves, turns or stops.
// Ports: Clk, Reset (sync, active-high); frame_tick, dir_req_valid, dir_req[1:0]
//   in; probe_x/probe_y[9:0] out, probe_wall in (combinational lookup);
//   pos_x/pos_y[9:0], dir[1:0], moving, busy out.
// Directions: 0=right 1=left 2=up 3=down.
// Optional feature: define PACMAN_TUNNEL_WRAP_EN to let the sprite wrap
// horizontally through the side tunnel instead of stopping at the edge.
module pacman_motion #(
  parameter int START_X = 216,
  parameter int START_Y = 352,
  parameter int STEP    = 1,
  parameter int WRAP_X  = 432
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       dir_req_valid,
  input  logic [1:0] dir_req,
  output logic [9:0] probe_x,
  output logic [9:0] probe_y,
  input  logic       probe_wall,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [1:0] dir,
  output logic       moving,
  output logic       busy
);

  localparam logic [9:0] SX = 10'(START_X);
  localparam logic [9:0] SY = 10'(START_Y);
  localparam logic [9:0] ST = 10'(STEP);
  localparam logic [9:0] WX = 10'(WRAP_X);
  localparam logic [9:0] OFS = 10'd15;

  localparam logic [1:0] D_R = 2'd0;
  localparam logic [1:0] D_L = 2'd1;
  localparam logic [1:0] D_U = 2'd2;
  localparam logic [1:0] D_D = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NEW_A,
    S_NEW_B,
    S_CUR_A,
    S_CUR_B,
    S_MOVE
  } state_e;

  state_e     state_q, state_d;
  logic [9:0] pos_x_q, pos_x_d;
  logic [9:0] pos_y_q, pos_y_d;
  logic [1:0] dir_q, dir_d;
  logic [1:0] req_q, req_d;
  logic [1:0] eval_q, eval_d;
  logic [1:0] mv_q, mv_d;
  logic       go_q, go_d;
  logic       wall_a_q, wall_a_d;
  logic       moving_q, moving_d;
  logic       busy_q, busy_d;
  logic [9:0] probe_x_q, probe_x_d;
  logic [9:0] probe_y_q, probe_y_d;

  logic [1:0] req_eff;
  logic       l_edge;
  logic       r_edge;
  logic       u_edge;
  logic [3:0] blk;
  logic       clear_new;
  logic       clear_cur;

  logic [9:0] cxs [4];
  logic [9:0] cys [4];
  logic [9:0] pax [4];
  logic [9:0] pay [4];
  logic [9:0] pbx [4];
  logic [9:0] pby [4];

  // A request arriving with the tick is the one evaluated.
  assign req_eff = dir_req_valid ? dir_req : req_q;

  assign l_edge = pos_x_q < ST;
  assign r_edge = ({1'b0, pos_x_q} + {1'b0, ST}) > {1'b0, WX};
  assign u_edge = pos_y_q < ST;

  // Candidate position and leading-edge probe points for every direction.
  // Edge candidates always hold the tunnel-wrapped value; without the
  // tunnel they are marked blocked, so that value is never committed.
  always_comb begin
    cxs[D_R] = r_edge ? 10'd0 : pos_x_q + ST;
    cys[D_R] = pos_y_q;
    cxs[D_L] = l_edge ? WX : pos_x_q - ST;
    cys[D_L] = pos_y_q;
    cxs[D_U] = pos_x_q;
    cys[D_U] = pos_y_q - ST;
    cxs[D_D] = pos_x_q;
    cys[D_D] = pos_y_q + ST;

    pax[D_R] = cxs[D_R] + OFS;
    pay[D_R] = cys[D_R];
    pbx[D_R] = cxs[D_R] + OFS;
    pby[D_R] = cys[D_R] + OFS;

    pax[D_L] = cxs[D_L];
    pay[D_L] = cys[D_L];
    pbx[D_L] = cxs[D_L];
    pby[D_L] = cys[D_L] + OFS;

    pax[D_U] = cxs[D_U];
    pay[D_U] = cys[D_U];
    pbx[D_U] = cxs[D_U] + OFS;
    pby[D_U] = cys[D_U];

    pax[D_D] = cxs[D_D];
    pay[D_D] = cys[D_D] + OFS;
    pbx[D_D] = cxs[D_D] + OFS;
    pby[D_D] = cys[D_D] + OFS;
  end

  // Moves rejected without consulting the maze.
  always_comb begin
    blk      = 4'b0000;
    blk[D_U] = u_edge;
`ifndef PACMAN_TUNNEL_WRAP_EN
    blk[D_L] = l_edge;
    blk[D_R] = r_edge;
`endif
  end

  assign clear_new = ~(wall_a_q | probe_wall | blk[eval_q]);
  assign clear_cur = clear_new;

  always_comb begin
    state_d   = state_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    dir_d     = dir_q;
    req_d     = req_eff;
    eval_d    = eval_q;
    mv_d      = mv_q;
    go_d      = go_q;
    wall_a_d  = wall_a_q;
    moving_d  = moving_q;
    busy_d    = busy_q;
    probe_x_d = probe_x_q;
    probe_y_d = probe_y_q;

    unique case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          eval_d    = req_eff;
          probe_x_d = pax[req_eff];
          probe_y_d = pay[req_eff];
          busy_d    = 1'b1;
          state_d   = S_NEW_A;
        end
      end
      S_NEW_A: begin
        wall_a_d  = probe_wall;
        probe_x_d = pbx[eval_q];
        probe_y_d = pby[eval_q];
        state_d   = S_NEW_B;
      end
      S_NEW_B: begin
        if (clear_new) begin
          go_d    = 1'b1;
          mv_d    = eval_q;
          state_d = S_MOVE;
        end else if (eval_q == dir_q) begin
          go_d    = 1'b0;
          state_d = S_MOVE;
        end else begin
          // Requested turn is blocked: try to keep going straight.
          eval_d    = dir_q;
          probe_x_d = pax[dir_q];
          probe_y_d = pay[dir_q];
          state_d   = S_CUR_A;
        end
      end
      S_CUR_A: begin
        wall_a_d  = probe_wall;
        probe_x_d = pbx[eval_q];
        probe_y_d = pby[eval_q];
        state_d   = S_CUR_B;
      end
      S_CUR_B: begin
        go_d    = clear_cur;
        mv_d    = eval_q;
        state_d = S_MOVE;
      end
      S_MOVE: begin
        if (go_q) begin
          pos_x_d  = cxs[mv_q];
          pos_y_d  = cys[mv_q];
          dir_d    = mv_q;
          moving_d = 1'b1;
        end else begin
          moving_d = 1'b0;
        end
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      pos_x_q   <= SX;
      pos_y_q   <= SY;
      dir_q     <= D_L;
      req_q     <= D_L;
      eval_q    <= D_L;
      mv_q      <= D_L;
      go_q      <= 1'b0;
      wall_a_q  <= 1'b0;
      moving_q  <= 1'b0;
      busy_q    <= 1'b0;
      probe_x_q <= '0;
      probe_y_q <= '0;
    end else begin
      state_q   <= state_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      dir_q     <= dir_d;
      req_q     <= req_d;
      eval_q    <= eval_d;
      mv_q      <= mv_d;
      go_q      <= go_d;
      wall_a_q  <= wall_a_d;
      moving_q  <= moving_d;
      busy_q    <= busy_d;
      probe_x_q <= probe_x_d;
      probe_y_q <= probe_y_d;
    end
  end

  assign probe_x = probe_x_q;
  assign probe_y = probe_y_q;
  assign pos_x   = pos_x_q;
  assign pos_y   = pos_y_q;
  assign dir     = dir_q;
  assign moving  = moving_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_pacman_motion.sv
// Bench for pacman_motion: maze model drives probe_wall, a reference
// model predicts each update, and a busy-fall monitor checks it.
module tb_pacman_motion;

  localparam int STEP   = 1;
  localparam int WRAP_X = 432;
`ifdef PACMAN_TUNNEL_WRAP_EN
  localparam bit TUNNEL = 1'b1;
`else
  localparam bit TUNNEL = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_tick;
  logic       dir_req_valid;
  logic [1:0] dir_req;
  logic [9:0] probe_x;
  logic [9:0] probe_y;
  logic       probe_wall;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic [1:0] dir;
  logic       moving;
  logic       busy;

  pacman_motion dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_tick   (frame_tick),
    .dir_req_valid(dir_req_valid),
    .dir_req      (dir_req),
    .probe_x      (probe_x),
    .probe_y      (probe_y),
    .probe_wall   (probe_wall),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .dir          (dir),
    .moving       (moving),
    .busy         (busy)
  );

  always #5 Clk = ~Clk;

  logic maze [0:28][0:27];

  always_comb begin
    probe_wall = 1'b0;
    if (int'(probe_x[9:4]) < 28 && int'(probe_y[9:4]) < 29)
      probe_wall = maze[int'(probe_y[9:4])][int'(probe_x[9:4])];
  end

  typedef struct {
    int x;
    int y;
    int d;
    int mv;
    int at_edge;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int m_x, m_y, m_dir, m_req, free_edge;
  bit rst_edge = 1'b0;
  bit busy_prev = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;
  always @(posedge Clk) rst_edge <= Reset;

  function automatic bit wall_at(int x, int y);
    int tx, ty;
    tx = (x % 1024) / 16;
    ty = (y % 1024) / 16;
    if (tx >= 28 || ty >= 29) return 1'b0;
    return maze[ty][tx];
  endfunction

  // Sprite occupies [x, x+15]; only its leading edge can meet a new wall.
  function automatic void try_move(int d, int x, int y,
                                   output int nx, output int ny,
                                   output bit ok);
    bit hit;
    int ax, ay, bx, by;
    nx = x;
    ny = y;
    hit = 1'b0;
    ok = 1'b1;
    case (d)
      0: if (x + STEP > WRAP_X) begin hit = 1; nx = 0; end
         else nx = x + STEP;
      1: if (x < STEP) begin hit = 1; nx = WRAP_X; end
         else nx = x - STEP;
      2: if (y < STEP) ok = 1'b0;
         else ny = y - STEP;
      default: ny = (y + STEP) % 1024;
    endcase
    if (hit && !TUNNEL) ok = 1'b0;
    case (d)
      0: begin ax = nx + 15; ay = ny; bx = nx + 15; by = ny + 15; end
      1: begin ax = nx; ay = ny; bx = nx; by = ny + 15; end
      2: begin ax = nx; ay = ny; bx = nx + 15; by = ny; end
      default: begin ax = nx; ay = ny + 15; bx = nx + 15; by = ny + 15; end
    endcase
    if (wall_at(ax, ay) || wall_at(bx, by)) ok = 1'b0;
    if (!ok) begin nx = x; ny = y; end
  endfunction

  function automatic void model_tick(int e);
    int nx, ny, lat, mv;
    bit ok;
    try_move(m_req, m_x, m_y, nx, ny, ok);
    if (ok) begin
      m_x = nx; m_y = ny; m_dir = m_req; mv = 1; lat = 3;
    end else if (m_req == m_dir) begin
      mv = 0; lat = 3;
    end else begin
      lat = 5;
      try_move(m_dir, m_x, m_y, nx, ny, ok);
      if (ok) begin m_x = nx; m_y = ny; mv = 1; end
      else mv = 0;
    end
    q.push_back('{m_x, m_y, m_dir, mv, e + lat});
    free_edge = e + lat + 1;
  endfunction

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic do_reset(int n);
    Reset = 1'b1;
    frame_tick = 1'b0;
    dir_req_valid = 1'b0;
    q.delete();
    repeat (n) @(posedge Clk);
    #1;
    Reset = 1'b0;
    m_x = 216; m_y = 352; m_dir = 1; m_req = 1;
    free_edge = cyc + 1;
  endtask

  // Called at posedge+1; the inputs are sampled on the next edge.
  task automatic drive(bit t, bit v, logic [1:0] d);
    frame_tick = t;
    dir_req_valid = v;
    dir_req = d;
    if (v) m_req = int'(d);
    if (t && cyc + 1 >= free_edge) model_tick(cyc + 1);
    @(posedge Clk);
    #1;
    frame_tick = 1'b0;
    dir_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (cyc < free_edge && guard < 50) begin
      @(posedge Clk);
      #1;
      guard++;
    end
  endtask

  task automatic walk(int d, int n);
    drive(1'b1, 1'b1, 2'(d));
    wait_idle();
    for (int i = 1; i < n; i++) begin
      drive(1'b1, 1'b0, 2'd0);
      wait_idle();
    end
  endtask

  always @(negedge Clk) begin
    if (!rst_edge && busy_prev && !busy) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL update: unexpected at cycle %0d pos=(%0d,%0d)",
                 cyc, pos_x, pos_y);
      end else begin
        mon_e = q.pop_front();
        if (int'(pos_x) != mon_e.x || int'(pos_y) != mon_e.y ||
            int'(dir) != mon_e.d || int'(moving) != mon_e.mv ||
            cyc != mon_e.at_edge) begin
          errors++;
          $display("FAIL update: got pos=(%0d,%0d) dir=%0d mv=%0d edge=%0d expected pos=(%0d,%0d) dir=%0d mv=%0d edge=%0d",
                   pos_x, pos_y, dir, moving, cyc,
                   mon_e.x, mon_e.y, mon_e.d, mon_e.mv, mon_e.at_edge);
        end
      end
    end
    busy_prev = busy;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic chk_reset_vals(string tag);
    chk({tag, "_pos_x"}, int'(pos_x), 216);
    chk({tag, "_pos_y"}, int'(pos_y), 352);
    chk({tag, "_dir"}, int'(dir), 1);
    chk({tag, "_moving"}, int'(moving), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_probe_x"}, int'(probe_x), 0);
    chk({tag, "_probe_y"}, int'(probe_y), 0);
  endtask

  initial begin
    for (int r = 0; r < 29; r++)
      for (int c = 0; c < 28; c++)
        maze[r][c] = (r == 0 || r == 28 ||
                      ((c == 0 || c == 27) && r != 15));
    maze[23][13] = 1'b1;
    maze[23][14] = 1'b1;
    maze[4][1]   = 1'b1;
    dir_req = 2'd0;

    do_reset(2);
    chk_reset_vals("reset");

    // First left step: probes and 3-clock update.
    drive(1'b1, 1'b1, 2'd1);
    chk("probeA_x", int'(probe_x), 215);
    chk("probeA_y", int'(probe_y), 352);
    @(posedge Clk);
    #1;
    chk("probeB_x", int'(probe_x), 215);
    chk("probeB_y", int'(probe_y), 367);
    wait_idle();
    chk("left_pos_x", int'(pos_x), 215);
    chk("left_moving", int'(moving), 1);

    // Down blocked by row 23: fall back to left, twice (req kept).
    do_reset(1);
    drive(1'b1, 1'b1, 2'd3);
    wait_idle();
    chk("fallback_pos_x", int'(pos_x), 215);
    chk("fallback_dir", int'(dir), 1);
    drive(1'b1, 1'b0, 2'd0);
    wait_idle();
    chk("req_kept_pos_x", int'(pos_x), 214);

    // Walk to (32,64), then hit the column-1 wall.
    walk(2, 288);
    walk(1, 182);
    drive(1'b1, 1'b0, 2'd0);
    wait_idle();
    chk("wall_pos_x", int'(pos_x), 32);
    chk("wall_pos_y", int'(pos_y), 64);
    chk("wall_moving", int'(moving), 0);

    // Into the tunnel row and off the left edge.
    walk(3, 176);
    walk(1, 32);
    chk("edge_pos_x", int'(pos_x), 0);
    drive(1'b1, 1'b0, 2'd0);
    wait_idle();
    chk("tunnel_pos_x", int'(pos_x), TUNNEL ? 432 : 0);
    chk("tunnel_moving", int'(moving), TUNNEL ? 1 : 0);

    // Ticks while busy are dropped.
    do_reset(1);
    drive(1'b1, 1'b1, 2'd3);
    drive(1'b1, 1'b0, 2'd0);
    drive(1'b1, 1'b0, 2'd0);
    wait_idle();
    chk("busy_tick_pos_x", int'(pos_x), 215);

    // Reset while in the fallback probe phase.
    do_reset(1);
    drive(1'b1, 1'b1, 2'd3);
    @(posedge Clk);
    #1;
    @(posedge Clk);
    #1;
    chk("cur_a_probe_x", int'(probe_x), 215);
    chk("cur_a_busy", int'(busy), 1);
    do_reset(1);
    chk_reset_vals("midrst");

    // Random maze and random stimulus.
    for (int r = 1; r < 28; r++)
      for (int c = 1; c < 27; c++)
        maze[r][c] = (r != 15) && ($urandom_range(0, 99) < 12);
    do_reset(2);
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
            2'($urandom_range(0, 3)));
    wait_idle();
    repeat (3) @(posedge Clk);
    #1;
    chk("scoreboard_drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
